vga_scanout_ctrl: RTL and testbench

- Sequences 640x480@60 VGA scan-out of the 256x240 NES frame buffer.
- Generates timing counters and sync; fetches 6-bit palette-index bytes from the frame-buffer RAM with 2x pixel/line doubling, centred in a 512x480 window.
- Outputs a delay-aligned index/sync/DE stream to the palette color decoder, which drives the DAC.
- Optionally sequences double-buffer bank swaps with the PPU.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing_gen.sv | 55 +++++
 rtl/vga_scanout_ctrl.sv | 89 ++++++++
 tb/tb_vga_scanout_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and control-word type for the VGA scan-out of the NES frame buffer.
// Define VGA_DOUBLE_BUFFER_EN to widen the read address with a bank bit.
package vga_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int H_FP       = 16;
    localparam int H_SYNC     = 96;
    localparam int H_BP       = 48;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE   = 480;
    localparam int V_FP       = 10;
    localparam int V_SYNC     = 2;
    localparam int V_BP       = 33;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_OFFSET   = 64;
    localparam int FB_W       = 256;
    localparam int FB_H       = 240;
    localparam int PIPE_DEPTH = 3;

    localparam logic [7:0] BORDER_INDEX = 8'h0F;

`ifdef VGA_DOUBLE_BUFFER_EN
    localparam int ADDR_W = 17;
`else
    localparam int ADDR_W = 16;
`endif

    // Per-pixel control bits that ride alongside the RAM access.
    typedef struct packed {
        logic win;
        logic de;
        logic hsync_n;
        logic vsync_n;
        logic frame;
    } ctl_t;

    localparam ctl_t CTL_RESET = '{win: 1'b0, de: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 h/v counters with the window, sync, blanking and swap-point decodes derived from them.
// Unaffected by VGA_DOUBLE_BUFFER_EN.
module vga_timing_gen
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output ctl_t       ctl,
    output logic [7:0] fb_x,
    output logic [7:0] fb_y,
    output logic       vblank,
    output logic       swap_pt
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] X_BEG  = 10'(X_OFFSET);
    localparam logic [9:0] X_END  = 10'(X_OFFSET + 2 * FB_W);

    logic [9:0] h;
    logic [9:0] v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    always_comb begin
        ctl.win     = (v < V_ACT) && (h >= X_BEG) && (h < X_END);
        ctl.de      = (h < H_ACT) && (v < V_ACT);
        ctl.hsync_n = !((h >= HS_BEG) && (h < HS_END));
        ctl.vsync_n = !((v >= VS_BEG) && (v < VS_END));
        ctl.frame   = (h == '0) && (v == '0);
    end

    // Each frame-buffer byte covers a 2x2 block of output pixels.
    assign fb_x    = 8'((h - X_BEG) >> 1);
    assign fb_y    = v[8:1];
    assign vblank  = (v >= V_ACT);
    assign swap_pt = (h == H_LAST) && (v == V_ACT - 10'd1);

endmodule

// File: rtl/vga_scanout_ctrl.sv
// VGA scan-out sequencer: frame-buffer fetch, 3-clk aligned index/sync/DE stream, optional bank swap.
// Define VGA_DOUBLE_BUFFER_EN for the banked frame buffer and swap_req/swap_ack handshake.
module vga_scanout_ctrl
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [7:0]        fb_rd_data,
    output logic [7:0]        pix_index,
    output logic              de,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              frame_start,
    output logic              vblank,
    input  logic              swap_req,
    output logic              swap_ack
);

    ctl_t              s0;
    logic [7:0]        fb_x;
    logic [7:0]        fb_y;
    logic              swap_pt;
    logic [ADDR_W-1:0] addr_next;
    ctl_t              pipe [1:PIPE_DEPTH-1];

    vga_timing_gen u_tim (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctl     (s0),
        .fb_x    (fb_x),
        .fb_y    (fb_y),
        .vblank  (vblank),
        .swap_pt (swap_pt)
    );

`ifdef VGA_DOUBLE_BUFFER_EN
    logic bank;

    // The swap lands on the last clk of the last visible line, so the new bank starts on a frame boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank     <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= swap_pt && swap_req;
            if (swap_pt && swap_req)
                bank <= ~bank;
        end
    end

    assign addr_next = {bank, fb_y, fb_x};
`else
    logic unused_swap;

    assign unused_swap = swap_req ^ swap_pt;
    assign swap_ack    = 1'b0;
    assign addr_next   = {fb_y, fb_x};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fb_rd_en    <= 1'b0;
            fb_rd_addr  <= '0;
            for (int i = 1; i < PIPE_DEPTH; i++)
                pipe[i] <= CTL_RESET;
            pix_index   <= BORDER_INDEX;
            de          <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            fb_rd_en <= s0.win;
            if (s0.win)
                fb_rd_addr <= addr_next;
            pipe[1] <= s0;
            for (int i = 2; i < PIPE_DEPTH; i++)
                pipe[i] <= pipe[i-1];
            // RAM data arrives alongside the control word two clks after stage 0.
            pix_index   <= pipe[PIPE_DEPTH-1].win ? fb_rd_data : BORDER_INDEX;
            de          <= pipe[PIPE_DEPTH-1].de;
            hsync_n     <= pipe[PIPE_DEPTH-1].hsync_n;
            vsync_n     <= pipe[PIPE_DEPTH-1].vsync_n;
            frame_start <= pipe[PIPE_DEPTH-1].frame;
        end
    end

endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// Directed bench for vga_scanout_ctrl: table of line-0/1 pixels plus stream checks against a
// cycle model; counters are jumped near frame boundaries to keep runs short.
module tb_vga_scanout_ctrl;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_rd_addr;
    logic [7:0]        fb_rd_data = 8'h00;
    logic [7:0]        pix_index;
    logic              de, hsync_n, vsync_n, frame_start, vblank;
    logic              swap_req;
    logic              swap_ack;

    vga_scanout_ctrl dut (
        .clk(clk), .rst_n(rst_n), .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data), .pix_index(pix_index), .de(de), .hsync_n(hsync_n),
        .vsync_n(vsync_n), .frame_start(frame_start), .vblank(vblank),
        .swap_req(swap_req), .swap_ack(swap_ack)
    );

    always #5 clk = ~clk;

    // RAM model: one-clk read latency, data = low address byte.
    always_ff @(posedge clk)
        if (fb_rd_en) fb_rd_data <= fb_rd_addr[7:0];

    typedef struct {
        int         k;
        logic [7:0] pix;
        logic       de;
        logic       hs;
    } vec_t;

    vec_t tv [16];

    int total = 0;
    int bad   = 0;
    int h_m, v_m, ph, pv, settle;
    int e_pix, e_de, e_hs, e_vs, e_fs, e_en, e_addr, e_ack, e_vb;
    int n_hs_low, n_vs_low, n_de, n_fs, n_en_vb, n_ack;
    logic exp_ack, exp_bank;
    logic [9:0] jh, jv;
    logic [7:0] cap_pix [1600];
    logic       cap_de  [1600];
    logic       cap_hs  [1600];

    task automatic check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic in_win(int hh, int vv);
        return (vv < 480) && (hh >= 64) && (hh < 576);
    endfunction

    task automatic clear_counts();
        n_hs_low = 0; n_vs_low = 0; n_de = 0; n_fs = 0; n_en_vb = 0; n_ack = 0;
    endtask

    task automatic model_reset();
        h_m = 0; v_m = 0; settle = 0; exp_bank = 1'b0; exp_ack = 1'b0;
    endtask

    task automatic step();
        logic r;
        logic ew;
        logic [ADDR_W-1:0] ea;
        int oh, ov;
        logic [7:0] ep;
        r = swap_req;
        @(posedge clk); #1;
        ph = h_m; pv = v_m;
        if (h_m == 799) begin
            h_m = 0;
            v_m = (v_m == 524) ? 0 : v_m + 1;
        end else begin
            h_m++;
        end
        settle++;
        exp_ack = 1'b0;
`ifdef VGA_DOUBLE_BUFFER_EN
        if (ph == 799 && pv == 479 && r) begin
            exp_ack  = 1'b1;
            exp_bank = ~exp_bank;
        end
`endif
        if (swap_ack !== exp_ack) e_ack++;
        if (swap_ack) n_ack++;
        if (vblank !== (v_m >= 480)) e_vb++;
        if (settle >= 1) begin
            ew = in_win(ph, pv);
            if (fb_rd_en !== ew) e_en++;
            if (fb_rd_en && pv >= 480) n_en_vb++;
            if (ew) begin
                ea = '0;
                ea[15:0] = 16'(((pv >> 1) << 8) | (((ph - 64) >> 1) & 255));
`ifdef VGA_DOUBLE_BUFFER_EN
                ea[16] = exp_bank;
`endif
                if (fb_rd_addr !== ea) e_addr++;
            end
        end
        if (settle >= 3) begin
            oh = h_m - 3; ov = v_m;
            if (oh < 0) begin
                oh += 800;
                ov = (v_m == 0) ? 524 : v_m - 1;
            end
            ep = in_win(oh, ov) ? 8'(((oh - 64) >> 1) & 255) : 8'h0F;
            if (pix_index !== ep) e_pix++;
            if (de !== (oh < 640 && ov < 480)) e_de++;
            if (hsync_n !== !(oh >= 656 && oh < 752)) e_hs++;
            if (vsync_n !== !(ov >= 490 && ov < 492)) e_vs++;
            if (frame_start !== (oh == 0 && ov == 0)) e_fs++;
            if (!hsync_n) n_hs_low++;
            if (!vsync_n) n_vs_low++;
            if (de) n_de++;
            if (frame_start) n_fs++;
            if (ov < 2) begin
                cap_pix[ov*800 + oh] = pix_index;
                cap_de[ov*800 + oh]  = de;
                cap_hs[ov*800 + oh]  = hsync_n;
            end
        end
    endtask

    task automatic run_to(int th, int tv_);
        int i;
        for (i = 0; i < 45000; i++) begin
            if (h_m == th && v_m == tv_) break;
            step();
        end
        if (i == 45000) check("run_to_timeout", 1, 0);
    endtask

    // Moves the stage-0 counters; the pipeline refills before it is checked again.
    task automatic jump(int nh, int nv);
        @(negedge clk);
        jh = 10'(nh); jv = 10'(nv);
        force dut.u_tim.h = jh;
        force dut.u_tim.v = jv;
        #1;
        release dut.u_tim.h;
        release dut.u_tim.v;
        h_m = nh; v_m = nv; settle = 0;
    endtask

    task automatic release_and_check_fs(string nm);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            check($sformatf("%s_fs_clk%0d", nm, i), int'(frame_start), (i == 3) ? 1 : 0);
        end
    endtask

    task automatic run_table(string nm);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_pix_k%0d", nm, tv[i].k), int'(cap_pix[tv[i].k]), int'(tv[i].pix));
            check($sformatf("%s_de_k%0d", nm, tv[i].k), int'(cap_de[tv[i].k]), int'(tv[i].de));
            check($sformatf("%s_hs_k%0d", nm, tv[i].k), int'(cap_hs[tv[i].k]), int'(tv[i].hs));
        end
    endtask

    initial begin
        tv[0]  = '{0,   8'h0F, 1'b1, 1'b1};
        tv[1]  = '{63,  8'h0F, 1'b1, 1'b1};
        tv[2]  = '{64,  8'h00, 1'b1, 1'b1};
        tv[3]  = '{65,  8'h00, 1'b1, 1'b1};
        tv[4]  = '{66,  8'h01, 1'b1, 1'b1};
        tv[5]  = '{67,  8'h01, 1'b1, 1'b1};
        tv[6]  = '{575, 8'hFF, 1'b1, 1'b1};
        tv[7]  = '{576, 8'h0F, 1'b1, 1'b1};
        tv[8]  = '{639, 8'h0F, 1'b1, 1'b1};
        tv[9]  = '{640, 8'h0F, 1'b0, 1'b1};
        tv[10] = '{655, 8'h0F, 1'b0, 1'b1};
        tv[11] = '{656, 8'h0F, 1'b0, 1'b0};
        tv[12] = '{751, 8'h0F, 1'b0, 1'b0};
        tv[13] = '{752, 8'h0F, 1'b0, 1'b1};
        tv[14] = '{864, 8'h00, 1'b1, 1'b1};
        tv[15] = '{866, 8'h01, 1'b1, 1'b1};
        for (int i = 0; i < 1600; i++) begin
            cap_pix[i] = 8'hAA; cap_de[i] = 1'bx; cap_hs[i] = 1'bx;
        end
        e_pix = 0; e_de = 0; e_hs = 0; e_vs = 0; e_fs = 0; e_en = 0; e_addr = 0; e_ack = 0; e_vb = 0;
        clear_counts();
        model_reset();
        rst_n = 1'b0;
        swap_req = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_pix", int'(pix_index), 8'h0F);
        check("rst_de", int'(de), 0);
        check("rst_hsync_n", int'(hsync_n), 1);
        check("rst_vsync_n", int'(vsync_n), 1);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_fb_rd_en", int'(fb_rd_en), 0);
        check("rst_fb_rd_addr", int'(fb_rd_addr), 0);
        check("rst_swap_ack", int'(swap_ack), 0);
        check("rst_vblank", int'(vblank), 0);

        // First ten lines after release
        release_and_check_fs("boot");
        run_to(2, 10);
        check("boot_hs_low_10lines", n_hs_low, 960);
        check("boot_de_10lines", n_de, 6400);
        check("boot_fs_count", n_fs, 1);
        run_table("boot");

        // Mid-frame reset at h=300, v=200
        jump(300, 200);
        repeat (10) step();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_pix", int'(pix_index), 8'h0F);
        check("midrst_de", int'(de), 0);
        check("midrst_hsync_n", int'(hsync_n), 1);
        check("midrst_vsync_n", int'(vsync_n), 1);
        check("midrst_fb_rd_en", int'(fb_rd_en), 0);
        check("midrst_fb_rd_addr", int'(fb_rd_addr), 0);
        check("midrst_frame_start", int'(frame_start), 0);
        repeat (4) @(posedge clk);
        release_and_check_fs("midrst");
        run_to(2, 2);
        run_table("midrst");

        // Bottom of frame: last visible line, vsync, wrap
        jump(0, 478);
        clear_counts();
        run_to(65, 479);
        check("y239_en", int'(fb_rd_en), 1);
        check("y239_addr", int'(fb_rd_addr[15:0]), 16'hEF00);
        run_to(100, 485);
        check("vblank_addr_hold", int'(fb_rd_addr[15:0]), 16'hEFFF);
        run_to(2, 1);
        check("vsync_low_clks", n_vs_low, 1600);
        check("hsync_low_48lines", n_hs_low, 4608);
        check("de_3lines", n_de, 1920);
        check("wrap_fs_count", n_fs, 1);
        check("rd_en_in_vblank", n_en_vb, 0);

`ifdef VGA_DOUBLE_BUFFER_EN
        // Request raised mid-frame waits for the swap point
        jump(0, 100);
        swap_req = 1'b1;
        clear_counts();
        repeat (50) step();
        check("swap_no_early_ack", n_ack, 0);
        jump(790, 479);
        run_to(0, 480);
        check("swap_ack_at_480", int'(swap_ack), 1);
        check("swap_vblank_at_ack", int'(vblank), 1);
        swap_req = 1'b0;
        jump(790, 524);
        run_to(70, 0);
        check("bank1_addr_msb", int'(fb_rd_addr[16]), 1);
        // Second request held: toggles back only at the next swap point
        swap_req = 1'b1;
        clear_counts();
        repeat (200) step();
        check("swap2_no_early_ack", n_ack, 0);
        jump(790, 479);
        run_to(0, 480);
        check("swap2_ack_at_480", int'(swap_ack), 1);
        swap_req = 1'b0;
        jump(790, 524);
        run_to(70, 0);
        check("bank0_addr_msb", int'(fb_rd_addr[16]), 0);
        // Request raised exactly on the swap-point clk
        jump(790, 479);
        run_to(799, 479);
        swap_req = 1'b1;
        step();
        check("swap_exact_ack", int'(swap_ack), 1);
        swap_req = 1'b0;
        // Request dropped before the swap point
        jump(700, 479);
        swap_req = 1'b1;
        clear_counts();
        repeat (50) step();
        swap_req = 1'b0;
        run_to(5, 480);
        check("swap_dropped_no_ack", n_ack, 0);
`else
        jump(790, 479);
        swap_req = 1'b1;
        clear_counts();
        repeat (20) step();
        swap_req = 1'b0;
        check("single_buf_no_ack", n_ack, 0);
`endif

        check("stream_pix", e_pix, 0);
        check("stream_de", e_de, 0);
        check("stream_hsync", e_hs, 0);
        check("stream_vsync", e_vs, 0);
        check("stream_frame_start", e_fs, 0);
        check("stream_fb_rd_en", e_en, 0);
        check("stream_fb_rd_addr", e_addr, 0);
        check("stream_swap_ack", e_ack, 0);
        check("stream_vblank", e_vb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
